// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax normalisation controller: default word
// format, FSM state encoding and signed saturation limits.
package softmax_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_Q     = 26;
  localparam int DEF_N     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_WAIT,
    ST_EMIT
  } state_t;

  // Largest / smallest signed value of a w-bit word (w up to 64).
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Limits for the default word width.
  localparam logic signed [DEF_WIDTH-1:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [DEF_WIDTH-1:0] SAT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/softmax_norm_ctrl_if.sv
// Stream and reciprocal-unit signals of the softmax normalisation controller.
// master = controller side, slave = environment side (source, sink, divider).
interface softmax_norm_ctrl_if import softmax_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_last;

  logic                    recip_start;
  logic signed [WIDTH-1:0] recip_a_q;
  logic                    recip_busy;
  logic                    recip_done;
  logic signed [WIDTH-1:0] recip_y_q;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_last;

  modport master (
    input  in_valid, in_data, in_last, recip_busy, recip_done, recip_y_q, out_ready,
    output in_ready, recip_start, recip_a_q, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, in_last, recip_busy, recip_done, recip_y_q, out_ready,
    input  in_ready, recip_start, recip_a_q, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sat_mul_q.sv
// Combinational Q-format multiply: full-width signed product, arithmetic
// shift right by Q, saturation back to a signed WIDTH-bit word.
module sat_mul_q import softmax_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int Q     = DEF_Q
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] y_o
);

  localparam logic signed [WIDTH-1:0] Y_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] Y_MIN = WIDTH'(sat_min(WIDTH));

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;
  logic                      ovf;

  assign a_ext   = a_i;
  assign b_ext   = b_i;
  assign prod    = a_ext * b_ext;
  assign shifted = prod >>> Q;
  // The result fits only if every bit above the WIDTH-bit sign equals it.
  assign ovf     = shifted[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){shifted[WIDTH-1]}};
  assign y_o     = !ovf ? shifted[WIDTH-1:0] : (shifted[2*WIDTH-1] ? Y_MIN : Y_MAX);

endmodule

// File: rtl/softmax_norm_ctrl.sv
// Softmax normalisation controller: buffers a vector of exp values, sums them
// with saturation, obtains 1/sum from an external reciprocal unit and streams
// out each element multiplied by that reciprocal.
// Optional: define SOFTMAX_NORM_TIMEOUT_EN to add a 512-cycle watchdog on WAIT.
module softmax_norm_ctrl import softmax_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int Q     = DEF_Q,
  parameter int N     = DEF_N
) (
  input  logic                clk,
  input  logic                rst,
  softmax_norm_ctrl_if.master bus,
  output logic                busy,
  output logic                div_zero,
  output logic                sat,
  output logic                err_len,
  output logic                err_timeout
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic signed [WIDTH-1:0] SUM_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] SUM_MIN = WIDTH'(sat_min(WIDTH));

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic signed [WIDTH-1:0] sum_q, sum_d;
  logic signed [WIDTH-1:0] recip_q, recip_d;
  logic signed [WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    sat_q, sat_d;
  logic                    div_zero_q, div_zero_d;
  logic                    err_len_q, err_len_d;
`ifdef SOFTMAX_NORM_TIMEOUT_EN
  logic [9:0]              wd_q, wd_d;
  logic                    err_timeout_q, err_timeout_d;
`endif

  logic signed [WIDTH-1:0] buffer [N];
  logic                    buf_we;
  logic                    accept;
  logic [WIDTH:0]          sum_wide;
  logic                    sum_ovf;
  logic signed [WIDTH-1:0] sum_sat;
  logic signed [WIDTH-1:0] prod_sat;

  assign accept   = bus.in_valid && bus.in_ready;
  assign sum_wide = {sum_q[WIDTH-1], sum_q} + {bus.in_data[WIDTH-1], bus.in_data};
  assign sum_ovf  = sum_wide[WIDTH] != sum_wide[WIDTH-1];
  assign sum_sat  = !sum_ovf ? sum_wide[WIDTH-1:0] : (sum_wide[WIDTH] ? SUM_MIN : SUM_MAX);

  sat_mul_q #(.WIDTH(WIDTH), .Q(Q)) u_mul (
    .a_i (buffer[idx_q[AW-1:0]]),
    .b_i (recip_q),
    .y_o (prod_sat)
  );

  // Next-state and datapath decode for the whole controller.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    count_d         = count_q;
    idx_d           = idx_q;
    sum_d           = sum_q;
    recip_d         = recip_q;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    out_last_d      = out_last_q;
    sat_d           = 1'b0;
    div_zero_d      = 1'b0;
    err_len_d       = 1'b0;
    buf_we          = 1'b0;
    bus.recip_start = 1'b0;
`ifdef SOFTMAX_NORM_TIMEOUT_EN
    wd_d            = wd_q;
    err_timeout_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          buf_we  = 1'b1;
          count_d = count_q + CW'(1);
          sum_d   = sum_sat;
          sat_d   = sum_ovf;
          state_d = ST_LOAD;
          if (bus.in_last || count_q == CW'(N - 1)) begin
            err_len_d = !bus.in_last;
            if (sum_sat == '0) begin
              div_zero_d = 1'b1;
              recip_d    = '0;
              idx_d      = '0;
              state_d    = ST_EMIT;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        if (!bus.recip_busy) begin
          bus.recip_start = 1'b1;
          state_d         = ST_WAIT;
`ifdef SOFTMAX_NORM_TIMEOUT_EN
          wd_d            = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (bus.recip_done) begin
          recip_d = bus.recip_y_q;
          idx_d   = '0;
          state_d = ST_EMIT;
        end
`ifdef SOFTMAX_NORM_TIMEOUT_EN
        else if (wd_q == 10'd511) begin
          err_timeout_d = 1'b1;
          count_d       = '0;
          sum_d         = '0;
          state_d       = ST_IDLE;
        end else begin
          wd_d = wd_q + 10'd1;
        end
`endif
      end
      ST_EMIT: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          count_d     = '0;
          sum_d       = '0;
          idx_d       = '0;
          state_d     = ST_IDLE;
        end else if (!out_valid_q || bus.out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = prod_sat;
          out_last_d  = (idx_q == count_q - CW'(1));
          idx_d       = idx_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the combinational block above uses blocking.
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      sum_q         <= '0;
      recip_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      sat_q         <= 1'b0;
      div_zero_q    <= 1'b0;
      err_len_q     <= 1'b0;
`ifdef SOFTMAX_NORM_TIMEOUT_EN
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      recip_q       <= recip_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      sat_q         <= sat_d;
      div_zero_q    <= div_zero_d;
      err_len_q     <= err_len_d;
`ifdef SOFTMAX_NORM_TIMEOUT_EN
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  // Element buffer write on each accepted beat.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; count_q gates which entries are ever read.
    if (buf_we) buffer[count_q[AW-1:0]] <= bus.in_data;
  end

  assign bus.in_ready  = !rst && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign bus.recip_a_q = sum_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = state_q != ST_IDLE;
  assign sat           = sat_q;
  assign div_zero      = div_zero_q;
  assign err_len       = err_len_q;
`ifdef SOFTMAX_NORM_TIMEOUT_EN
  assign err_timeout   = err_timeout_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule
